// File: rtl/mem_stage_wait_if.sv
// Handshake/bus bundle between EXECUTE, the MEM stage and WRITEBACK.
// The stage uses the slave modport; the upstream pipeline uses master.
interface mem_stage_wait_if #(
  parameter int RD_W = 5,
  parameter int SW_W = 13
);
  logic            XM_MemtoReg;
  logic            XM_RegWrite;
  logic            XM_MemRead;
  logic            XM_MemWrite;
  logic [1:0]      XM_Size;
  logic            XM_Unsigned;
  logic [31:0]     ALUout;
  logic [RD_W-1:0] XM_RD;
  logic [31:0]     XM_MD;
  logic [SW_W-1:0] sw;
  logic            mem_stall;
  logic            MW_MemtoReg;
  logic            MW_RegWrite;
  logic [31:0]     MW_ALUout;
  logic [31:0]     MDR;
  logic [RD_W-1:0] MW_RD;
  logic            MW_Misalign;

  modport master (
    output XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_Size,
           XM_Unsigned, ALUout, XM_RD, XM_MD, sw,
    input  mem_stall, MW_MemtoReg, MW_RegWrite, MW_ALUout, MDR, MW_RD,
           MW_Misalign
  );

  modport slave (
    input  XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_Size,
           XM_Unsigned, ALUout, XM_RD, XM_MD, sw,
    output mem_stall, MW_MemtoReg, MW_RegWrite, MW_ALUout, MDR, MW_RD,
           MW_Misalign
  );
endinterface

// File: rtl/mem_stage_wait.sv
// MEM stage: byte/half/word data memory with configurable access latency,
// post-reset clear/preload sequencer and the XM->MW pipeline register.
module mem_stage_wait #(
  parameter int          ADDR_W  = 6,
  parameter int          RD_W    = 5,
  parameter int          SW_W    = 13,
  parameter int          LAT     = 0,
  parameter logic [31:0] INIT_W1 = 32'd1
) (
  input logic             clk,
  input logic             rst,
  mem_stage_wait_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return lane[0];
      default: return lane != 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   return uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] md,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] r;
    r = old;
    case (size)
      2'b00:   r[{lane, 3'b000} +: 8] = md[7:0];
      2'b01:   if (lane[1]) r[31:16] = md[15:0]; else r[15:0] = md[15:0];
      default: r = md;
    endcase
    return r;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              mw_memtoreg_q, mw_memtoreg_d;
  logic              mw_regwrite_q, mw_regwrite_d;
  logic [31:0]       mw_aluout_q, mw_aluout_d;
  logic [31:0]       mdr_q, mdr_d;
  logic [RD_W-1:0]   mw_rd_q, mw_rd_d;
  logic              mw_misalign_q, mw_misalign_d;
  logic [31:0]       mem_q [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic [31:0]       rd_word;
  logic              mem_op, mis, complete;

  assign word_idx = bus.ALUout[ADDR_W+1:2];
  assign lane     = bus.ALUout[1:0];
  assign rd_word  = mem_q[word_idx];
  assign mem_op   = bus.XM_MemRead | bus.XM_MemWrite;
  assign mis      = misaligned(bus.XM_Size, lane);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    complete  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = word_idx;
    mem_wdata = store_merge(rd_word, bus.XM_MD, bus.XM_Size, lane);
    case (state_q)
      S_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = idx_q;
        if (idx_q == '0)                 mem_wdata = 32'(bus.sw);
        else if (idx_q == ADDR_W'(1))    mem_wdata = INIT_W1;
        else                             mem_wdata = 32'd0;
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == {ADDR_W{1'b1}}) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (mem_op && LAT != 0) begin
          state_d = S_WAIT;
          cnt_d   = 4'(LAT - 1);
        end else begin
          complete = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_INIT;
        idx_d   = '0;
      end
    endcase
    // A store takes precedence over a simultaneous load; misaligned stores are dropped.
    if (complete && bus.XM_MemWrite && !mis) mem_we = 1'b1;
  end

  always_comb begin
    mw_memtoreg_d = 1'b0;
    mw_regwrite_d = 1'b0;
    mw_aluout_d   = 32'd0;
    mw_rd_d       = '0;
    mw_misalign_d = 1'b0;
    mdr_d         = mdr_q;
    if (complete) begin
      mw_memtoreg_d = bus.XM_MemtoReg;
      mw_regwrite_d = bus.XM_RegWrite;
      mw_aluout_d   = bus.ALUout;
      mw_rd_d       = bus.XM_RD;
      mw_misalign_d = mem_op & mis;
      if (bus.XM_MemRead && !bus.XM_MemWrite)
        mdr_d = mis ? 32'd0 : load_extract(rd_word, bus.XM_Size, lane, bus.XM_Unsigned);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_INIT;
      cnt_q         <= 4'd0;
      idx_q         <= '0;
      mw_memtoreg_q <= 1'b0;
      mw_regwrite_q <= 1'b0;
      mw_aluout_q   <= 32'd0;
      mdr_q         <= 32'd0;
      mw_rd_q       <= '0;
      mw_misalign_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      mw_memtoreg_q <= mw_memtoreg_d;
      mw_regwrite_q <= mw_regwrite_d;
      mw_aluout_q   <= mw_aluout_d;
      mdr_q         <= mdr_d;
      mw_rd_q       <= mw_rd_d;
      mw_misalign_q <= mw_misalign_d;
    end
  end

  // Memory is never cleared by reset; reset forces INIT, which rewrites every word.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.mem_stall   = ~complete;
  assign bus.MW_MemtoReg = mw_memtoreg_q;
  assign bus.MW_RegWrite = mw_regwrite_q;
  assign bus.MW_ALUout   = mw_aluout_q;
  assign bus.MDR         = mdr_q;
  assign bus.MW_RD       = mw_rd_q;
  assign bus.MW_Misalign = mw_misalign_q;
endmodule

// File: doc/mem_stage_wait.md
Name: mem_stage_wait

Overview:
- Parametrised successor of the pipeline MEM stage: data memory plus the XM→MW pipeline register.
- Adds byte/half/word access with load sign/zero extension and misalignment detection.
- Adds a configurable memory latency, with a stall handshake back to the pipeline.
- Adds a post-reset init sequencer that clears memory and preloads the switch value.
- Sits between EXECUTE and WRITEBACK.

Parameters:
- ADDR_W, 6, word-index width; depth = 2**ADDR_W words of 32 bits.
- RD_W, 5, destination register index width.
- SW_W, 13, switch input width; must be ≤32.
- LAT, 0, extra wait cycles per memory access; range 0..15.
- INIT_W1, 32'd1, value preloaded into word 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- XM_MemtoReg  in  1  pass-through control.
- XM_RegWrite  in  1  pass-through control.
- XM_MemRead  in  1  load request.
- XM_MemWrite  in  1  store request.
- XM_Size  in  2  access size: 00 byte, 01 half, 10 and 11 word.
- XM_Unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- ALUout  in  32  byte address / ALU result.
- XM_RD  in  RD_W  destination register.
- XM_MD  in  32  store data, right-aligned.
- sw  in  SW_W  value preloaded into word 0 during init.
- mem_stall  out  1  upstream must hold its XM inputs while this is 1.
- MW_MemtoReg  out  1  registered.
- MW_RegWrite  out  1  registered.
- MW_ALUout  out  32  registered.
- MDR  out  32  registered load data.
- MW_RD  out  RD_W  registered.
- MW_Misalign  out  1  registered, one-cycle flag per misaligned access.

Behaviour:
- Addressing:
  - Word index = ALUout[ADDR_W+1:2]; higher address bits are ignored (wrap).
  - Byte lane = ALUout[1:0].
- Misaligned access: half with ALUout[0]=1, or word with ALUout[1:0]≠0.
  - A misaligned store does not write memory.
  - A misaligned load returns MDR=0.
  - MW_Misalign=1 for that access's MW cycle.
- Reset (rst=0, async): all MW outputs, MDR and MW_Misalign go to 0. FSM goes to INIT with init index=0. mem_stall=1.
- FSM states: INIT, IDLE, WAIT.
  - INIT: writes one word per cycle.
    - Word 0 gets sw zero-extended; word 1 gets INIT_W1; all others get 0.
    - After index DEPTH-1 is written, go to IDLE. Total DEPTH cycles, mem_stall=1 throughout.
    - MW register loads a bubble every cycle: all controls 0, MW_ALUout=0.
  - IDLE, no memory op, or LAT=0: the access completes this edge (single-cycle, as in the previous generation). mem_stall=0. MW loads the XM values.
  - IDLE, memory op with LAT>0: go to WAIT, cnt=LAT-1. mem_stall=1 combinationally in this same cycle. MW loads a bubble.
  - WAIT: mem_stall=1 while cnt≠0; cnt decrements each cycle and MW loads a bubble.
    - When cnt=0: mem_stall=0, the access completes on this edge, MW loads the XM values, return to IDLE.
- Total occupancy of a memory op = LAT+1 cycles. A non-memory op always takes 1 cycle.
- Access completion edge:
  - Store writes byte lanes by size:
    - Byte: XM_MD[7:0] to lane ALUout[1:0].
    - Half: XM_MD[15:0] to lanes {1,0} or {3,2}.
    - Word: the full word.
    - Other lanes are preserved.
  - Load: MDR = selected byte/half, sign- or zero-extended to 32; a word load returns the full word.
  - MDR holds its value when there is no load.
- XM_MemRead and XM_MemWrite both 1: treated as a store only; MDR holds.
- Load of the address stored in the previous access returns the newly written data (write completes on an earlier edge).
- Reset asserted mid-WAIT or mid-INIT: abort immediately; a pending store is not performed. Restart INIT on release.
- Memory contents are not reset asynchronously; they are rewritten only by INIT.

Test Plan:
- Reset release, sw=13'h1ABC, ADDR_W=6 → mem_stall=1 for exactly 64 cycles. Then a word load at addr 0 gives MDR=32'h00001ABC; addr 4 gives 1; addr 8 gives 0.
- LAT=0: store word 32'hDEADBEEF at addr 0x10, then byte loads at 0x13 signed and unsigned → MDR=32'hFFFFFFDE, then 32'h000000DE. Half load at 0x10 signed → 32'hFFFFBEEF.
- LAT=3: one load → mem_stall high exactly 3 cycles. MW_RegWrite=0 during those cycles, 1 on completion. A following ALU op passes in 1 cycle.
- Store byte 8'h55 at 0x21 over word 32'h11223344 → word becomes 32'h11225544. Half store at 0x22 misaligned? No: lanes {3,2} is aligned. Half store at 0x23 → MW_Misalign=1, memory unchanged.
- LAT=5, rst pulsed low during the 2nd WAIT cycle of a store to 0x30 → outputs 0 at once, INIT reruns, word at 0x30 reads 0 afterwards.
- Read and write asserted together at 0x40 with XM_MD=7 → word becomes 7, MDR keeps its previous value.
